// File: rtl/alu_instruction_encoder.sv
// ---------------------------------------------------------------------------
// alu_instruction_encoder
//   Packs ALU operation fields into a 32-bit ALU instruction word, drops
//   illegal bundles (constant form on anything but add/sub) and queues legal
//   words in a small FIFO toward the instruction stream.
//
// Ports
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   : field bundle handshake (in_ready = not full)
//   in_const_c .. in_copy_select : ALU instruction fields
//   out_valid / out_ready : encoded word handshake (out_valid = not empty)
//   out_instruction       : FIFO head word (0 while empty)
//   reject                : one-cycle pulse after an illegal bundle is accepted
//   reject_count          : saturating count of rejected bundles
//   occupancy             : FIFO entries held
// ---------------------------------------------------------------------------
module alu_instruction_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_const_c,
  input  logic [2:0]                 in_alu_op,
  input  logic                       in_alu_form,
  input  logic [1:0]                 in_alu_vec_perci,
  input  logic [3:0]                 in_alu_config,
  input  logic [3:0]                 in_a_select,
  input  logic [3:0]                 in_b_select,
  input  logic [3:0]                 in_c_select,
  input  logic [3:0]                 in_d_select,
  input  logic [15:0]                in_constant,
  input  logic [3:0]                 in_copy_select,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instruction,
  output logic                       reject,
  output logic [CNT_W-1:0]           reject_count,
  output logic [$clog2(DEPTH):0]     occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [31:0]      r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [OW-1:0]    r_occ;
  logic             r_reject;
  logic [CNT_W-1:0] r_rej_cnt;

  logic             w_accept;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_word;

  // Handshakes depend on registered occupancy only.
  assign in_ready  = (r_occ < OW'(DEPTH));
  assign out_valid = (r_occ != '0);

  assign w_accept  = in_valid & in_ready;
  assign w_illegal = in_const_c & (in_alu_op != 3'b000) & (in_alu_op != 3'b100);
  // Illegal bundles complete the handshake but never reach the FIFO.
  assign w_push    = w_accept & ~w_illegal;
  assign w_pop     = out_valid & out_ready;

  // Field packing. const_c=1 with a non add/sub op never gets pushed, so the
  // constant branch only ever encodes add/sub.
  always_comb begin
    w_word        = '0;
    w_word[28]    = in_const_c;
    w_word[27:25] = in_alu_op;
    w_word[24]    = in_alu_form;
    if (in_const_c) begin
      w_word[23:22] = in_alu_vec_perci;
      w_word[19:16] = in_a_select;
      w_word[15:0]  = in_constant;
    end else if (in_alu_op == 3'b010) begin
      // Copy reuses the vec/reserved bits [23:20] for the copy selector.
      w_word[23:20] = in_copy_select;
      w_word[19:16] = in_alu_config;
      w_word[15:0]  = {in_a_select, in_b_select, in_c_select, in_d_select};
    end else begin
      w_word[23:22] = in_alu_vec_perci;
      w_word[19:16] = in_alu_config;
      w_word[15:0]  = {in_a_select, in_b_select, in_c_select, in_d_select};
    end
  end

  // Storage carries no reset; validity is tracked by occupancy.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_word;
  end

  // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_occ     <= '0;
      r_reject  <= 1'b0;
      r_rej_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
      r_reject <= w_accept & w_illegal;
      if (w_accept && w_illegal && (r_rej_cnt != '1))
        r_rej_cnt <= r_rej_cnt + CNT_W'(1);
    end
  end

  assign out_instruction = out_valid ? r_mem[r_rd_ptr] : '0;
  assign reject          = r_reject;
  assign reject_count    = r_rej_cnt;
  assign occupancy       = r_occ;

endmodule

// File: tb/tb_alu_instruction_encoder.sv
module tb_alu_instruction_encoder;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;

  typedef struct packed {
    logic        c;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  cfg;
    logic [3:0]  a, b, cc, d;
    logic [15:0] k;
    logic [3:0]  cp;
  } bundle_t;

  logic        clk = 0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        in_const_c;
  logic [2:0]  in_alu_op;
  logic        in_alu_form;
  logic [1:0]  in_alu_vec_perci;
  logic [3:0]  in_alu_config, in_a_select, in_b_select, in_c_select, in_d_select;
  logic [15:0] in_constant;
  logic [3:0]  in_copy_select;
  logic        out_valid, out_ready;
  logic [31:0] out_instruction;
  logic        reject;
  logic [CNT_W-1:0] reject_count;
  logic [$clog2(DEPTH):0] occupancy;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  alu_instruction_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_const_c(in_const_c), .in_alu_op(in_alu_op), .in_alu_form(in_alu_form),
    .in_alu_vec_perci(in_alu_vec_perci), .in_alu_config(in_alu_config),
    .in_a_select(in_a_select), .in_b_select(in_b_select),
    .in_c_select(in_c_select), .in_d_select(in_d_select),
    .in_constant(in_constant), .in_copy_select(in_copy_select),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .reject(reject), .reject_count(reject_count), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Reference encoding of a legal bundle.
  function automatic logic [31:0] enc(input bundle_t b);
    logic [31:0] w;
    w = '0;
    w[28] = b.c; w[27:25] = b.op; w[24] = b.form;
    if (b.c) begin
      w[23:22] = b.vec; w[19:16] = b.a; w[15:0] = b.k;
    end else if (b.op == 3'b010) begin
      w[23:20] = b.cp; w[19:16] = b.cfg; w[15:0] = {b.a, b.b, b.cc, b.d};
    end else begin
      w[23:22] = b.vec; w[19:16] = b.cfg; w[15:0] = {b.a, b.b, b.cc, b.d};
    end
    return w;
  endfunction

  function automatic logic is_legal(input bundle_t b);
    return !b.c || b.op == 3'b000 || b.op == 3'b100;
  endfunction

  function automatic bundle_t rand_legal();
    bundle_t b;
    b = bundle_t'({$urandom, $urandom});
    if (b.c) b.op = ($urandom_range(0, 1) != 0) ? 3'b100 : 3'b000;
    return b;
  endfunction

  task automatic drive(input bundle_t b);
    in_const_c = b.c; in_alu_op = b.op; in_alu_form = b.form;
    in_alu_vec_perci = b.vec; in_alu_config = b.cfg;
    in_a_select = b.a; in_b_select = b.b; in_c_select = b.cc; in_d_select = b.d;
    in_constant = b.k; in_copy_select = b.cp;
  endtask

  // Scoreboard consumer: a pop happens at the next rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h expected none", out_instruction);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        if (out_instruction !== e) begin
          bad++;
          $display("FAIL sb_word got=%h exp=%h", out_instruction, e);
        end
      end
    end
  end

  // Drives one bundle until accepted; returns at accept edge + 1.
  task automatic send(input bundle_t b);
    logic acc;
    acc = 0;
    drive(b);
    in_valid = 1;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        if (is_legal(b)) sb.push_back(enc(b));
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout in_ready never high");
    end
  endtask

  task automatic drain();
    out_ready = 1;
    for (int i = 0; i < 200 && (sb.size() != 0 || out_valid); i++) begin
      @(posedge clk); #1;
    end
    total++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain left=%0d out_valid=%b exp 0/0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    bundle_t b;
    b = '0; b.cfg = 4'h3; b.a = 1; b.b = 2; b.cc = 3; b.d = 4;
    drive(b);
    reset = 1; in_valid = 1; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 0 || occupancy !== 0 || reject_count !== 0 ||
        reject !== 0 || out_instruction !== 0 || in_ready !== 1) begin
      bad++;
      $display("FAIL reset_state ov=%b occ=%0d rc=%0d rej=%b oi=%h ir=%b exp 0/0/0/0/0/1",
               out_valid, occupancy, reject_count, reject, out_instruction, in_ready);
    end
    in_valid = 0; reset = 0;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 0 || occupancy !== 0) begin
      bad++;
      $display("FAIL reset_no_enqueue ov=%b occ=%0d exp 0/0", out_valid, occupancy);
    end
  endtask

  task automatic check_word(input string nm, input bundle_t b, input logic [31:0] exp);
    out_ready = 1;
    send(b);
    total++;
    if (out_valid !== 1 || out_instruction !== exp) begin
      bad++;
      $display("FAIL %s ov=%b word=%h exp 1/%h", nm, out_valid, out_instruction, exp);
    end
    @(posedge clk); #1;
    total++;
    if (out_valid !== 0) begin
      bad++;
      $display("FAIL %s_one_cycle ov=%b exp 0", nm, out_valid);
    end
  endtask

  task automatic test_encodings();
    bundle_t b;
    b = '0; b.cfg = 4'h3; b.a = 1; b.b = 2; b.cc = 3; b.d = 4;
    check_word("reg_add", b, 32'h0003_1234);
    b = '0; b.c = 1; b.op = 3'b100; b.a = 5; b.k = 16'hBEEF;
    b.cfg = 4'hF; b.b = 4'hF; b.cc = 4'hF; b.d = 4'hF;
    check_word("const_sub", b, 32'h1805_BEEF);
    b = '0; b.op = 3'b010; b.vec = 2'b11; b.cp = 4'hA; b.a = 1; b.cc = 2;
    check_word("copy", b, 32'h04A0_1020);
  endtask

  task automatic test_illegal();
    bundle_t b;
    b = '0; b.c = 1; b.op = 3'b010; b.a = 7; b.k = 16'h1234;
    out_ready = 1;
    send(b);
    total++;
    if (reject !== 1 || occupancy !== 0 || reject_count !== 1 || out_valid !== 0) begin
      bad++;
      $display("FAIL illegal_first rej=%b occ=%0d rc=%0d ov=%b exp 1/0/1/0",
               reject, occupancy, reject_count, out_valid);
    end
    @(posedge clk); #1;
    total++;
    if (reject !== 0 || reject_count !== 1) begin
      bad++;
      $display("FAIL illegal_pulse rej=%b rc=%0d exp 0/1", reject, reject_count);
    end
    drive(b);
    in_valid = 1;
    repeat (300) @(posedge clk);
    #1; in_valid = 0;
    total++;
    if (reject_count !== 8'hFF || occupancy !== 0) begin
      bad++;
      $display("FAIL reject_saturate rc=%0d occ=%0d exp 255/0", reject_count, occupancy);
    end
    // Illegal accepted while a pop happens: occupancy drops by one.
    out_ready = 0;
    send(rand_legal());
    send(rand_legal());
    drive(b); in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0; out_ready = 0;
    total++;
    if (occupancy !== 1 || reject !== 1) begin
      bad++;
      $display("FAIL illegal_with_pop occ=%0d rej=%b exp 1/1", occupancy, reject);
    end
    drain();
  endtask

  task automatic test_backpressure();
    bundle_t b5;
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(rand_legal());
    total++;
    if (in_ready !== 0 || occupancy !== 4) begin
      bad++;
      $display("FAIL full ir=%b occ=%0d exp 0/4", in_ready, occupancy);
    end
    b5 = rand_legal();
    drive(b5); in_valid = 1; out_ready = 1;
    @(negedge clk);
    total++;
    if (in_ready !== 0) begin
      bad++;
      $display("FAIL no_passthrough ir=%b exp 0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (occupancy !== 3 || in_ready !== 1) begin
      bad++;
      $display("FAIL after_pop occ=%0d ir=%b exp 3/1", occupancy, in_ready);
    end
    @(negedge clk);
    if (in_ready) sb.push_back(enc(b5));
    @(posedge clk); #1;
    in_valid = 0;
    total++;
    if (occupancy !== 3) begin
      bad++;
      $display("FAIL push_pop_occ occ=%0d exp 3", occupancy);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic done;
    done = 0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(rand_legal());
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
      end
    join
    drain();
  endtask

  task automatic test_reset_midstream();
    out_ready = 0;
    send(rand_legal());
    send(rand_legal());
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sb.delete();
    total++;
    if (occupancy !== 0 || out_valid !== 0 || out_instruction !== 0 || reject_count !== 0) begin
      bad++;
      $display("FAIL reset_midstream occ=%0d ov=%b oi=%h rc=%0d exp 0/0/0/0",
               occupancy, out_valid, out_instruction, reject_count);
    end
  endtask

  initial begin
    reset = 1; in_valid = 0; out_ready = 0;
    drive('0);
    #1;
    test_reset();
    test_encodings();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
